pose_replay_sequencer: RTL and testbench

Records up to DEPTH four-channel servo poses from the live keyboard-driven servo values and replays them as a timed sequence. During replay, each channel's command moves toward the stored pose with a bounded slew per tick, then holds for a dwell period. The block sits between data_controller's live servo outputs and the pwm_driver instances. It also produces the replaying / tot_state / current_state status consumed by vga_display.

---
 rtl/pose_replay_sequencer_pkg.sv | 15 +
 rtl/pose_replay_sequencer_if.sv | 36 +++
 rtl/pose_replay_sequencer_slew_channel.sv | 30 +++
 rtl/pose_replay_sequencer.sv | 150 +++++++++++++++
 tb/tb_pose_replay_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pose_replay_sequencer_pkg.sv
// Shared servo definitions: command width, reset position and the sequencer
// state encoding used by this block and data_controller.
package servo_pkg;

    localparam int unsigned DATA_W = 13;
    localparam logic [DATA_W-1:0] RESET_POS = 13'd1500;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RAMP  = 2'd2,
        DWELL = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pose_replay_sequencer_if.sv
// Live servo inputs, control pulses and servo/status outputs of the pose sequencer.
interface pose_replay_sequencer_if #(
    parameter int unsigned DATA_W = servo_pkg::DATA_W
);

    logic [DATA_W-1:0] i_live_servo0;
    logic [DATA_W-1:0] i_live_servo1;
    logic [DATA_W-1:0] i_live_servo2;
    logic [DATA_W-1:0] i_live_servo3;
    logic              i_record;
    logic              i_play;
    logic              i_stop;
    logic              i_clear;
    logic [DATA_W-1:0] o_servo0;
    logic [DATA_W-1:0] o_servo1;
    logic [DATA_W-1:0] o_servo2;
    logic [DATA_W-1:0] o_servo3;
    logic              o_replaying;
    logic [4:0]        o_tot_state;
    logic [4:0]        o_current_state;

    modport master (
        output i_live_servo0, i_live_servo1, i_live_servo2, i_live_servo3,
        output i_record, i_play, i_stop, i_clear,
        input  o_servo0, o_servo1, o_servo2, o_servo3,
        input  o_replaying, o_tot_state, o_current_state
    );

    modport slave (
        input  i_live_servo0, i_live_servo1, i_live_servo2, i_live_servo3,
        input  i_record, i_play, i_stop, i_clear,
        output o_servo0, o_servo1, o_servo2, o_servo3,
        output o_replaying, o_tot_state, o_current_state
    );

endinterface

// File: rtl/pose_replay_sequencer_slew_channel.sv
// One servo channel's bounded slew step toward its target, plus an arrival flag.
module pose_slew_channel #(
    parameter int unsigned       DATA_W = servo_pkg::DATA_W,
    parameter logic [DATA_W-1:0] STEP   = DATA_W'(20)
) (
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] target,
    output logic [DATA_W-1:0] nxt,
    output logic              at_target
);

    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] step_s;

    // One extra bit keeps the signed difference of two unsigned commands exact.
    always_comb begin
        diff   = $signed({1'b0, target}) - $signed({1'b0, cur});
        step_s = $signed({1'b0, STEP});
        if (diff > step_s) begin
            nxt = cur + STEP;
        end else if (diff < -step_s) begin
            nxt = cur - STEP;
        end else begin
            nxt = target;
        end
    end

    assign at_target = (cur == target);

endmodule

// File: rtl/pose_replay_sequencer.sv
// Records four-channel servo poses from live commands and replays them with
// per-tick slew limiting and a dwell at each pose.
module pose_replay_sequencer #(
    parameter int unsigned       DATA_W       = servo_pkg::DATA_W,
    parameter int unsigned       DEPTH        = 16,
    parameter int unsigned       TICK_CYCLES  = 500000,
    parameter logic [DATA_W-1:0] STEP         = 13'd20,
    parameter int unsigned       DWELL_CYCLES = 50000000,
    parameter bit                LOOP         = 1'b0,
    parameter logic [DATA_W-1:0] RESET_POS    = servo_pkg::RESET_POS
) (
    input logic                      i_clk,
    input logic                      i_rst_n,
    pose_replay_sequencer_if.slave   bus
);

    import servo_pkg::*;

    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam logic [4:0]  DEPTH_C    = 5'(DEPTH);
    localparam logic [31:0] TICK_LAST  = 32'(TICK_CYCLES - 1);
    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);

    typedef logic [DATA_W-1:0] chan_t;

    seq_state_t          state, state_nx;
    logic [4:0]          count, current;
    logic [31:0]         tick, dwell;
    chan_t               out [4];
    chan_t               target [4];
    chan_t               live [4];
    chan_t               slew [4];
    logic [3:0]          at_target;
    logic [4*DATA_W-1:0] mem [DEPTH];
    logic                do_clear, do_play, do_record, all_at, last_slot;

    assign live[0] = bus.i_live_servo0;
    assign live[1] = bus.i_live_servo1;
    assign live[2] = bus.i_live_servo2;
    assign live[3] = bus.i_live_servo3;

    assign bus.o_servo0        = out[0];
    assign bus.o_servo1        = out[1];
    assign bus.o_servo2        = out[2];
    assign bus.o_servo3        = out[3];
    assign bus.o_replaying     = (state != IDLE);
    assign bus.o_tot_state     = count;
    assign bus.o_current_state = current;

    for (genvar c = 0; c < 4; c++) begin : g_ch
        pose_slew_channel #(.DATA_W(DATA_W), .STEP(STEP)) u_slew (
            .cur       (out[c]),
            .target    (target[c]),
            .nxt       (slew[c]),
            .at_target (at_target[c])
        );
    end

    // In IDLE only the highest-priority asserted pulse acts, even if it is then ignored.
    always_comb begin
        do_clear  = 1'b0;
        do_play   = 1'b0;
        do_record = 1'b0;
        all_at    = &at_target;
        last_slot = (current >= count - 5'd1);
        state_nx  = state;
        unique case (state)
            IDLE: begin
                if (bus.i_clear) begin
                    do_clear = 1'b1;
                end else if (bus.i_play) begin
                    do_play = (count != '0);
                end else if (bus.i_record) begin
                    do_record = (count != DEPTH_C);
                end
                if (do_play) state_nx = LOAD;
            end
            LOAD:  state_nx = bus.i_stop ? IDLE : RAMP;
            RAMP: begin
                if (bus.i_stop)  state_nx = IDLE;
                else if (all_at) state_nx = DWELL;
            end
            DWELL: begin
                if (bus.i_stop) begin
                    state_nx = IDLE;
                end else if (dwell == DWELL_LAST) begin
                    state_nx = (!last_slot || LOOP) ? LOAD : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count   <= '0;
            current <= '0;
            tick    <= '0;
            dwell   <= '0;
            for (int unsigned c = 0; c < 4; c++) begin
                out[c]    <= RESET_POS;
                target[c] <= RESET_POS;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    out <= live;
                    if (do_clear)       count <= '0;
                    else if (do_record) count <= count + 5'd1;
                    if (do_play) begin
                        current <= '0;
                        tick    <= '0;
                    end
                end
                LOAD: begin
                    for (int unsigned c = 0; c < 4; c++) begin
                        target[c] <= mem[current[IDX_W-1:0]][c*DATA_W +: DATA_W];
                    end
                    tick <= '0;
                end
                RAMP: begin
                    if (!bus.i_stop) begin
                        if (tick == TICK_LAST) begin
                            tick <= '0;
                            out  <= slew;
                        end else begin
                            tick <= tick + 32'd1;
                        end
                    end
                    dwell <= '0;
                end
                DWELL: begin
                    dwell <= dwell + 32'd1;
                    if (state_nx == LOAD) current <= last_slot ? 5'd0 : current + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_record) mem[count[IDX_W-1:0]] <= {live[3], live[2], live[1], live[0]};
    end

endmodule

// File: tb/tb_pose_replay_sequencer.sv
// Randomized and directed checks of pose_replay_sequencer (LOOP=0 and LOOP=1
// instances) against a timeline model of the replay.
module tb_pose_replay_sequencer;

    localparam int DEPTH = 4;
    localparam int TICK  = 4;
    localparam int STEPV = 100;
    localparam int DWELL = 8;
    localparam int PLAN_MAX = 2048;

    typedef logic [3:0][12:0] pose_t;
    typedef struct packed {
        pose_t      out;
        logic [4:0] cur;
        logic       rep;
    } entry_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    pose_t live_p;
    logic  rec = 1'b0, play = 1'b0, stop = 1'b0, clr = 1'b0;

    always #5 clk = ~clk;

    pose_replay_sequencer_if bus0();
    pose_replay_sequencer_if bus1();

    assign bus0.i_live_servo0 = live_p[0];
    assign bus0.i_live_servo1 = live_p[1];
    assign bus0.i_live_servo2 = live_p[2];
    assign bus0.i_live_servo3 = live_p[3];
    assign bus0.i_record = rec;
    assign bus0.i_play   = play;
    assign bus0.i_stop   = stop;
    assign bus0.i_clear  = clr;
    assign bus1.i_live_servo0 = live_p[0];
    assign bus1.i_live_servo1 = live_p[1];
    assign bus1.i_live_servo2 = live_p[2];
    assign bus1.i_live_servo3 = live_p[3];
    assign bus1.i_record = rec;
    assign bus1.i_play   = play;
    assign bus1.i_stop   = stop;
    assign bus1.i_clear  = clr;

    pose_replay_sequencer #(.DEPTH(DEPTH), .TICK_CYCLES(TICK), .STEP(13'd100),
                            .DWELL_CYCLES(DWELL), .LOOP(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave));

    pose_replay_sequencer #(.DEPTH(DEPTH), .TICK_CYCLES(TICK), .STEP(13'd100),
                            .DWELL_CYCLES(DWELL), .LOOP(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave));

    int errors = 0;
    int checks = 0;

    // Model state, index 0 = LOOP=0 instance, 1 = LOOP=1 instance
    pose_t  m_out [2];
    int     m_count [2];
    int     m_cur [2];
    bit     m_rep [2];
    pose_t  m_mem [2][DEPTH];
    entry_t plan [2][PLAN_MAX];
    int     plen [2];
    int     pidx [2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [12:0] approach(input int a, input int t, input int amt);
        int d;
        d = t - a;
        if (d <= amt && d >= -amt) return 13'(t);
        return (d > 0) ? 13'(a + amt) : 13'(a - amt);
    endfunction

    task automatic add(input int m, input pose_t p, input int s, input bit r);
        if (plen[m] < PLAN_MAX) begin
            plan[m][plen[m]] = '{out: p, cur: 5'(s), rep: r};
            plen[m]++;
        end
    endtask

    // Expected per-edge outputs for one pass over all stored poses, starting at the
    // edge that leaves the load of slot 0.
    task automatic gen_pass(input int m, input pose_t start);
        pose_t p, t, q;
        int n, d, k;
        p = start;
        plen[m] = 0;
        pidx[m] = 0;
        for (int s = 0; s < m_count[m]; s++) begin
            add(m, p, s, 1'b1);
            t = m_mem[m][s];
            n = 0;
            for (int c = 0; c < 4; c++) begin
                d = int'(t[c]) - int'(p[c]);
                if (d < 0) d = -d;
                if ((d + STEPV - 1) / STEPV > n) n = (d + STEPV - 1) / STEPV;
            end
            for (int j = 1; j <= n * TICK + 1; j++) begin
                k = j / TICK;
                if (k > n) k = n;
                for (int c = 0; c < 4; c++) q[c] = approach(int'(p[c]), int'(t[c]), k * STEPV);
                add(m, q, s, 1'b1);
            end
            p = t;
            for (int j = 1; j < DWELL; j++) add(m, p, s, 1'b1);
            if (s < m_count[m] - 1) add(m, p, s + 1, 1'b1);
            else if (m == 1)        add(m, p, 0, 1'b1);
            else                    add(m, p, s, 1'b0);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) m_out[m][c] = 13'd1500;
            m_count[m] = 0;
            m_cur[m]   = 0;
            m_rep[m]   = 1'b0;
            plen[m]    = 0;
            pidx[m]    = 0;
        end
    endtask

    task automatic model_step(input int m);
        entry_t e;
        if (!m_rep[m]) begin
            if (clr) begin
                m_count[m] = 0;
            end else if (play) begin
                if (m_count[m] > 0) begin
                    m_rep[m] = 1'b1;
                    m_cur[m] = 0;
                    gen_pass(m, live_p);
                end
            end else if (rec) begin
                if (m_count[m] < DEPTH) begin
                    m_mem[m][m_count[m]] = live_p;
                    m_count[m]++;
                end
            end
            m_out[m] = live_p;
        end else if (stop) begin
            m_rep[m] = 1'b0;
        end else begin
            if (pidx[m] >= plen[m]) gen_pass(m, m_out[m]);
            e = plan[m][pidx[m]];
            pidx[m]++;
            m_out[m] = e.out;
            m_cur[m] = int'(e.cur);
            m_rep[m] = e.rep;
        end
    endtask

    task automatic compare_one(input int m, input logic [12:0] o0, input logic [12:0] o1,
                               input logic [12:0] o2, input logic [12:0] o3, input logic rep,
                               input logic [4:0] tot, input logic [4:0] cur);
        chk($sformatf("m%0d_out0", m), int'(o0), int'(m_out[m][0]));
        chk($sformatf("m%0d_out1", m), int'(o1), int'(m_out[m][1]));
        chk($sformatf("m%0d_out2", m), int'(o2), int'(m_out[m][2]));
        chk($sformatf("m%0d_out3", m), int'(o3), int'(m_out[m][3]));
        chk($sformatf("m%0d_replaying", m), int'(rep), int'(m_rep[m]));
        chk($sformatf("m%0d_tot_state", m), int'(tot), m_count[m]);
        chk($sformatf("m%0d_current_state", m), int'(cur), m_cur[m]);
    endtask

    task automatic compare();
        compare_one(0, bus0.o_servo0, bus0.o_servo1, bus0.o_servo2, bus0.o_servo3,
                    bus0.o_replaying, bus0.o_tot_state, bus0.o_current_state);
        compare_one(1, bus1.o_servo0, bus1.o_servo1, bus1.o_servo2, bus1.o_servo3,
                    bus1.o_replaying, bus1.o_tot_state, bus1.o_current_state);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        compare();
    endtask

    task automatic set_live(input int v);
        for (int c = 0; c < 4; c++) live_p[c] = 13'(v);
    endtask

    int exp_tot [5] = '{1, 2, 3, 4, 4};
    int exp_seq [4] = '{0, 1, 0, 1};
    int seq [4];
    int ns, prev;

    initial begin
        set_live(1000);
        model_reset();

        // reset values and first pass-through
        @(negedge clk);
        chk("rst_out0", int'(bus0.o_servo0), 1500);
        chk("rst_out3", int'(bus0.o_servo3), 1500);
        chk("rst_replaying", int'(bus0.o_replaying), 0);
        chk("rst_tot", int'(bus0.o_tot_state), 0);
        compare();
        rst_n = 1'b1;
        cycle();
        chk("live_out0", int'(bus0.o_servo0), 1000);
        chk("live_out3", int'(bus0.o_servo3), 1000);

        // five records into four slots, then play with an empty store
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < 4; c++) live_p[c] = 13'(600 + 100 * i + c);
            rec = 1'b1;
            cycle();
            rec = 1'b0;
            chk($sformatf("tot_after_rec%0d", i), int'(bus0.o_tot_state), exp_tot[i]);
        end
        clr = 1'b1; cycle(); clr = 1'b0;
        chk("tot_after_clear", int'(bus0.o_tot_state), 0);
        play = 1'b1; cycle(); play = 1'b0;
        chk("empty_play_rep0", int'(bus0.o_replaying), 0);
        chk("empty_play_rep1", int'(bus1.o_replaying), 0);

        // single pose 1250 replayed from live 1000
        set_live(1250);
        rec = 1'b1; cycle(); rec = 1'b0;
        set_live(1000);
        cycle();
        play = 1'b1; cycle(); play = 1'b0;
        chk("play_rep", int'(bus0.o_replaying), 1);
        set_live(900);
        for (int i = 1; i <= 23; i++) begin
            cycle();
            case (i)
                5:  chk("ramp_1100", int'(bus0.o_servo0), 1100);
                9:  chk("ramp_1200", int'(bus0.o_servo0), 1200);
                13: chk("ramp_1250", int'(bus0.o_servo0), 1250);
                21: chk("dwell_rep", int'(bus0.o_replaying), 1);
                22: begin
                        chk("done_rep", int'(bus0.o_replaying), 0);
                        chk("done_hold", int'(bus0.o_servo0), 1250);
                    end
                23: chk("done_live", int'(bus0.o_servo0), 900);
                default: ;
            endcase
        end

        // looping replay of two poses, stopped during the ramp
        stop = 1'b1; cycle(); stop = 1'b0;
        clr = 1'b1; cycle(); clr = 1'b0;
        set_live(1000); rec = 1'b1; cycle();
        set_live(1050); cycle(); rec = 1'b0;
        set_live(1000); cycle();
        play = 1'b1; cycle(); play = 1'b0;
        ns = 0;
        prev = -1;
        for (int i = 0; i < 4; i++) seq[i] = -1;
        for (int b = 0; b < 300 && ns < 4; b++) begin
            if (int'(bus1.o_current_state) != prev) begin
                prev = int'(bus1.o_current_state);
                seq[ns] = prev;
                ns++;
            end
            if (ns < 4) cycle();
        end
        chk("loop_seq_len", ns, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("loop_seq%0d", i), seq[i], exp_seq[i]);
        cycle();
        cycle();
        stop = 1'b1; cycle(); stop = 1'b0;
        chk("stop_rep", int'(bus1.o_replaying), 0);
        set_live(777);
        cycle();
        chk("stop_live", int'(bus1.o_servo0), 777);

        // coincident pulses
        set_live(1000);
        play = 1'b1; rec = 1'b1; stop = 1'b1;
        cycle();
        play = 1'b0; rec = 1'b0; stop = 1'b0;
        chk("coinc_rep", int'(bus0.o_replaying), 1);
        chk("coinc_tot", int'(bus0.o_tot_state), 2);
        repeat (3) cycle();
        stop = 1'b1; clr = 1'b1;
        cycle();
        stop = 1'b0; clr = 1'b0;
        chk("dwell_stop_rep", int'(bus0.o_replaying), 0);
        chk("dwell_stop_tot", int'(bus0.o_tot_state), 2);

        // asynchronous reset during the ramp
        set_live(1400);
        play = 1'b1; cycle(); play = 1'b0;
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("async_out0", int'(bus0.o_servo0), 1500);
        chk("async_out2", int'(bus1.o_servo2), 1500);
        chk("async_rep", int'(bus0.o_replaying), 0);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("post_rst_tot", int'(bus0.o_tot_state), 0);
        chk("post_rst_live", int'(bus0.o_servo0), 1400);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(7, 0) == 0) live_p[c] = 13'($urandom_range(3000, 0));
            rec  = ($urandom_range(5, 0) == 0);
            play = ($urandom_range(29, 0) == 0);
            stop = ($urandom_range(59, 0) == 0);
            clr  = ($urandom_range(79, 0) == 0);
            cycle();
        end
        rec = 1'b0; play = 1'b0; stop = 1'b0; clr = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
